// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch front end: a one-entry line buffer backed by a single-outstanding bus read, with a timeout.
// Latency: hits return data combinationally; a miss returns data one cycle after ack. stall_req_o holds the cpu until then.
module inst_fetch_ctrl #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  input  logic        inv_i,
  output logic [31:0] rom_data_o,
  output logic        stall_req_o,
  output logic        fetch_err_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_data_i,
  input  logic        bus_err_i
);

  typedef enum logic {IDLE, REQ} state_e;

  localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          valid_q, valid_d;
  logic [29:0]   tag_q,   tag_d;
  logic [31:0]   data_q,  data_d;
  logic [29:0]   addr_q,  addr_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          err_q,   err_d;

  logic hit;
  logic miss;
  logic unused_addr_bits;

  // Byte-offset bits never matter for a word-granular buffer.
  assign unused_addr_bits = ^rom_addr_i[1:0];

  assign hit  = rom_ce_i & valid_q & (tag_q == rom_addr_i[31:2]);
  assign miss = rom_ce_i & ~hit;

  assign rom_data_o  = hit ? data_q : 32'h0;
  assign stall_req_o = miss & rst;
  assign bus_req_o   = (state_q == REQ);
  assign bus_addr_o  = {addr_q, 2'b00};
  assign fetch_err_o = err_q;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss) begin
          state_d = REQ;
          addr_d  = rom_addr_i[31:2];
          cnt_d   = '0;
        end
      end
      REQ: begin
        // Ack is checked first so that an ack in the final wait cycle still delivers real data.
        if (bus_ack_i) begin
          state_d = IDLE;
          valid_d = 1'b1;
          tag_d   = addr_q;
          data_d  = bus_err_i ? NOP_INST : bus_data_i;
          err_d   = bus_err_i;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          valid_d = 1'b1;
          tag_d   = addr_q;
          data_d  = NOP_INST;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (inv_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: hand-computed expectations for miss, hit, error, timeout, redirect, reset and invalidate.
module tb_inst_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic        inv_i;
  logic [31:0] rom_data_o;
  logic        stall_req_o;
  logic        fetch_err_o;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_ack_i;
  logic [31:0] bus_data_i;
  logic        bus_err_i;

  int n_vec = 0;
  int n_err = 0;

  inst_fetch_ctrl #(.TIMEOUT(16), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce_i    (rom_ce_i),
    .rom_addr_i  (rom_addr_i),
    .inv_i       (inv_i),
    .rom_data_o  (rom_data_o),
    .stall_req_o (stall_req_o),
    .fetch_err_o (fetch_err_o),
    .bus_req_o   (bus_req_o),
    .bus_addr_o  (bus_addr_o),
    .bus_ack_i   (bus_ack_i),
    .bus_data_i  (bus_data_i),
    .bus_err_i   (bus_err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_req;
    rst = 1'b0; rom_ce_i = 1'b1; rom_addr_i = 32'h4; inv_i = 1'b0;
    bus_ack_i = 1'b0; bus_data_i = 32'h0; bus_err_i = 1'b0;
    #3;
    chk("rst_stall", stall_req_o, 0);
    chk("rst_data",  rom_data_o, 0);
    chk("rst_req",   bus_req_o, 0);
    chk("rst_addr",  bus_addr_o, 0);
    chk("rst_err",   fetch_err_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;

    // Cold miss at 0x4, ack on the 4th stalled cycle.
    chk("cold_stall0", stall_req_o, 1);
    chk("cold_noreq0", bus_req_o, 0);
    step(); #1;
    chk("cold_req",   bus_req_o, 1);
    chk("cold_baddr", bus_addr_o, 32'h4);
    chk("cold_stall1", stall_req_o, 1);
    step(); #1;
    chk("cold_stall2", stall_req_o, 1);
    step(); bus_ack_i = 1'b1; bus_data_i = 32'h3401_1100; #1;
    chk("cold_stall3", stall_req_o, 1);
    step(); bus_ack_i = 1'b0; bus_data_i = 32'hDEAD_BEEF; #1;
    chk("cold_stall4", stall_req_o, 0);
    chk("cold_data",   rom_data_o, 32'h3401_1100);
    chk("cold_req_dn", bus_req_o, 0);

    // Hit with a different byte offset in the same word.
    rom_addr_i = 32'h6; #1;
    chk("hit_data",  rom_data_o, 32'h3401_1100);
    chk("hit_stall", stall_req_o, 0);
    step(); #1;
    chk("hit_noreq", bus_req_o, 0);

    // Bus error fill.
    rom_addr_i = 32'h8; #1;
    chk("berr_stall", stall_req_o, 1);
    step(); bus_ack_i = 1'b1; bus_err_i = 1'b1; bus_data_i = 32'h1234_5678; #1;
    step(); bus_ack_i = 1'b0; bus_err_i = 1'b0; #1;
    chk("berr_data",  rom_data_o, NOP);
    chk("berr_stall2", stall_req_o, 0);
    chk("berr_pulse", fetch_err_o, 1);
    step(); #1;
    chk("berr_pulse_end", fetch_err_o, 0);

    // Timeout: request stays up exactly 16 cycles.
    rom_addr_i = 32'hC;
    step();
    n_req = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus_req_o) break;
      n_req++;
      chk("to_no_err", fetch_err_o, 0);
      step();
    end
    #1;
    chk("to_cycles", n_req, 16);
    chk("to_pulse",  fetch_err_o, 1);
    chk("to_data",   rom_data_o, NOP);
    step(); #1;
    chk("to_pulse_end", fetch_err_o, 0);

    // Ack in the 16th wait cycle beats the timeout.
    rom_addr_i = 32'h20;
    step();
    repeat (15) step();
    bus_ack_i = 1'b1; bus_data_i = 32'hCAFE_0001; #1;
    chk("late_req", bus_req_o, 1);
    step(); bus_ack_i = 1'b0; #1;
    chk("late_data",  rom_data_o, 32'hCAFE_0001);
    chk("late_noerr", fetch_err_o, 0);
    chk("late_stall", stall_req_o, 0);

    // Address change mid-request: fill goes to 0x10, then a new request for 0x14.
    rom_addr_i = 32'h10;
    step(); #1;
    chk("redir_baddr1", bus_addr_o, 32'h10);
    rom_addr_i = 32'h14;
    step(); bus_ack_i = 1'b1; bus_data_i = 32'h1111_0010; #1;
    chk("redir_hold", bus_addr_o, 32'h10);
    step(); bus_ack_i = 1'b0; rom_addr_i = 32'h10; #1;
    chk("redir_fill10", rom_data_o, 32'h1111_0010);
    rom_addr_i = 32'h14; #1;
    chk("redir_miss14", stall_req_o, 1);
    step(); #1;
    chk("redir_req2",   bus_req_o, 1);
    chk("redir_baddr2", bus_addr_o, 32'h14);
    bus_ack_i = 1'b1; bus_data_i = 32'h1111_0014;
    step(); bus_ack_i = 1'b0; #1;
    chk("redir_data14", rom_data_o, 32'h1111_0014);

    // Reset during a request drops bus_req_o at once; later ack ignored.
    rom_addr_i = 32'h40;
    step(); #1;
    chk("mrst_req", bus_req_o, 1);
    rst = 1'b0; #1;
    chk("mrst_req_dn", bus_req_o, 0);
    chk("mrst_baddr",  bus_addr_o, 0);
    chk("mrst_stall",  stall_req_o, 0);
    step(); rst = 1'b1; rom_ce_i = 1'b0; bus_ack_i = 1'b1; bus_data_i = 32'h9999_9999;
    step(); bus_ack_i = 1'b0; #1;
    chk("ce0_data",  rom_data_o, 0);
    chk("ce0_stall", stall_req_o, 0);
    chk("ce0_noreq", bus_req_o, 0);
    rom_ce_i = 1'b1; #1;
    chk("mrst_miss", stall_req_o, 1);

    // Invalidate coincident with the ack: invalidate wins.
    step(); bus_ack_i = 1'b1; inv_i = 1'b1; bus_data_i = 32'h2222_0040;
    step(); bus_ack_i = 1'b0; inv_i = 1'b0; #1;
    chk("inv_ack_stall", stall_req_o, 1);
    chk("inv_ack_data",  rom_data_o, 0);
    chk("inv_ack_idle",  bus_req_o, 0);
    step(); #1;
    chk("inv_rereq", bus_req_o, 1);

    // Invalidate during a request does not abort it.
    inv_i = 1'b1;
    step(); inv_i = 1'b0; #1;
    chk("inv_noabort", bus_req_o, 1);
    bus_ack_i = 1'b1; bus_data_i = 32'h3333_0040;
    step(); bus_ack_i = 1'b0; #1;
    chk("inv_fill", rom_data_o, 32'h3333_0040);

    // Plain invalidate makes the next access miss.
    inv_i = 1'b1;
    step(); inv_i = 1'b0; #1;
    chk("inv_miss", stall_req_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, is the maximum number of cycles spent waiting for bus_ack_i.
REQ-002 Parameter NOP_INST, default 32'h00000000, is the instruction supplied after a failed fetch.
REQ-003 Port clk  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  in  1  is the reset; it is asynchronous and active-low (rst=0 resets the block).
REQ-005 Port rom_ce_i  in  1  is the fetch enable from the cpu pc stage.
REQ-006 Port rom_addr_i  in  32  is the fetch byte address from the cpu.
REQ-007 Port inv_i  in  1  invalidates the line buffer.
REQ-008 Port rom_data_o  out  32  is the instruction returned to the cpu.
REQ-009 Port stall_req_o  out  1  requests a pipeline stall; the instruction is not yet valid.
REQ-010 Port fetch_err_o  out  1  is a one-cycle pulse on fetch failure.
REQ-011 Port bus_req_o  out  1  is the memory-bus request.
REQ-012 Port bus_addr_o  out  32  is the word-aligned bus address.
REQ-013 Port bus_ack_i  in  1  is the bus completion strobe.
REQ-014 Port bus_data_i  in  32  is the bus read data, valid with bus_ack_i.
REQ-015 Port bus_err_i  in  1  is the bus error, sampled only with bus_ack_i.

Function
REQ-016 The block SHALL hold a one-entry line buffer: valid bit, tag = addr[31:2], and 32-bit data; addr[1:0] SHALL be ignored everywhere.
REQ-017 Hit = rom_ce_i & valid & (tag == rom_addr_i[31:2]), evaluated combinationally; on hit, rom_data_o = buffer data and stall_req_o = 0 in the same cycle.
REQ-018 With rom_ce_i=0: rom_data_o = 0 and stall_req_o = 0, and no new request is started.
REQ-019 Miss (rom_ce_i=1 and not hit): stall_req_o = 1 combinationally and rom_data_o = 0.
REQ-020 FSM states are IDLE and REQ; reset state is IDLE.
REQ-021 IDLE -> REQ on a clock edge where a miss is present; the block latches bus_addr_o = {rom_addr_i[31:2],2'b00} at that edge.
REQ-022 In REQ: bus_req_o = 1, and bus_addr_o is held stable until the transaction ends; bus_req_o = 0 in IDLE.
REQ-023 REQ -> IDLE on an edge with bus_ack_i=1 and bus_err_i=0: buffer data <= bus_data_i, tag <= latched address, valid <= 1; the next cycle hits if the address is unchanged. Miss-to-data latency is ack cycle + 1.
REQ-024 REQ -> IDLE on an edge with bus_ack_i=1 and bus_err_i=1: buffer data <= NOP_INST, tag <= latched address, valid <= 1, and fetch_err_o = 1 for exactly the next cycle.
REQ-025 Wait counter: cleared on entry to REQ and incremented each REQ cycle without ack; when it reaches TIMEOUT-1 without ack, the block SHALL behave as REQ-024 (NOP fill, error pulse, bus_req_o drops).
REQ-026 An ack arriving in the same cycle as the timeout takes priority over the timeout.
REQ-027 A change of rom_addr_i or rom_ce_i during REQ SHALL NOT abort the transaction; the fill completes for the latched address, and a further miss then starts a new request from IDLE.
REQ-028 inv_i=1 clears valid at the edge; if coincident with a fill, the invalidate wins (valid=0).
REQ-029 inv_i SHALL NOT abort an outstanding REQ.
REQ-030 bus_ack_i while in IDLE SHALL be ignored.
REQ-031 fetch_err_o SHALL never be high for two consecutive cycles from a single failure.

Reset
REQ-032 While rst=0, asynchronously: state = IDLE, valid = 0, tag = 0, data = 0, counter = 0, bus_req_o = 0, bus_addr_o = 0, fetch_err_o = 0, stall_req_o = 0, rom_data_o = 0.
REQ-033 Reset asserted during REQ SHALL drop bus_req_o immediately; any later ack SHALL be ignored.

Verification
REQ-034 Cold miss: after reset, rom_ce_i=1, addr 0x00000004, ack 3 cycles later with data 0x34011100 -> stall_req_o high for 4 cycles, then rom_data_o=0x34011100 with stall low.
REQ-035 Hit: repeat addr 0x00000006 -> immediate hit, rom_data_o=0x34011100, no bus_req_o.
REQ-036 Bus error: miss at 0x00000008, ack with bus_err_i=1 -> rom_data_o=NOP_INST next cycle, fetch_err_o pulse of 1 cycle.
REQ-037 Timeout: miss at 0x0000000C, no ack -> bus_req_o high for exactly 16 cycles, then NOP fill and error pulse; an ack in the 16th cycle wins instead.
REQ-038 Address change mid-REQ: miss at 0x10, switch to 0x14 before ack -> fill tag 0x10, second request issued for 0x14.
REQ-039 Reset mid-REQ and inv_i coincident with ack -> bus_req_o drops immediately and later ack ignored; after invalidate, valid=0 and next access misses.
